// File: rtl/data_reader.sv
// Read-side sequencer: walks buffer slots 0..length-1 through a 1-cycle synchronous read
// and hands each entry to the cipher stage over valid/ready. DATA_READER_REVERSE_EN reads descending.
module data_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] length,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic [ADDR_W-1:0] len_q, len_nxt;
   logic              is_last;

`ifdef DATA_READER_REVERSE_EN
   assign is_last = (idx == '0);
`else
   assign is_last = (idx == len_q - ONE);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         len_q    <= '0;
         out_data <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         len_q <= len_nxt;
         // read data arrives the cycle after the FETCH strobe
         if (state == CAPTURE) out_data <= rd_data;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      len_nxt   = len_q;
      case (state)
         IDLE: begin
            if (start) begin
               len_nxt = length;
`ifdef DATA_READER_REVERSE_EN
               idx_nxt = length - ONE;
`else
               idx_nxt = '0;
`endif
               state_nxt = (length == '0) ? DONE : FETCH;
            end
         end
         FETCH:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = PRESENT;
         PRESENT: begin
            if (out_ready) begin
               if (is_last) begin
                  state_nxt = DONE;
               end else begin
`ifdef DATA_READER_REVERSE_EN
                  idx_nxt = idx - ONE;
`else
                  idx_nxt = idx + ONE;
`endif
                  state_nxt = FETCH;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // all outputs decode directly from registered state
   assign rd_en     = (state == FETCH);
   assign rd_addr   = idx;
   assign out_valid = (state == PRESENT);
   assign out_last  = (state == PRESENT) && is_last;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_data_reader.sv
// Randomized bench for data_reader: a buffer model plus an address-order reference
// model checks every read strobe, presented entry, last flag and done pulse.
module tb_data_reader;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;

   logic              clock = 1'b0;
   logic              reset, start, out_ready;
   logic [ADDR_W-1:0] length;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data, out_data;
   logic              out_valid, out_last, busy, done;

   logic [DATA_W-1:0] mem [0:31];
   int tests = 0;
   int fails = 0;

   data_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset), .start(start), .length(length),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // synchronous buffer with one cycle of read latency
   always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // k-th address of a pass of length len
   function automatic int exp_addr(input int len, input int k);
`ifdef DATA_READER_REVERSE_EN
      return len - 1 - k;
`else
      return k;
`endif
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 32; i++) mem[i] = DATA_W'($urandom);
   endtask

   task automatic run_pass(input int len, input int stall_pct, input int stall_at,
                           input int stall_n, input bit noise);
      int n_rd, n_out, stall_left, cyc, budget;
      bit was_wait, finished, seen_valid;
      n_rd = 0; n_out = 0; stall_left = stall_n; cyc = 0;
      was_wait = 0; finished = 0; seen_valid = 0;
      budget = 20 * len + 16;
      @(negedge clock);
      start = 1'b1; length = ADDR_W'(len); out_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      while (!finished && cyc < budget) begin
         cyc++;
         if (rd_en) begin
            if (n_rd < len) check("rd_addr", rd_addr, exp_addr(len, n_rd));
            else check("rd_extra", 1, 0);
            n_rd++;
         end
         if (was_wait) check("valid_held", out_valid, 1);
         if (out_valid) begin
            if (!seen_valid) check("latency", cyc, 3);
            seen_valid = 1;
            if (n_out < len) begin
               check("out_data", out_data, mem[exp_addr(len, n_out)]);
               check("out_last", out_last, (n_out == len - 1));
            end else begin
               check("valid_extra", 1, 0);
            end
         end
         if (done) begin
            check("done_entries", n_out, len);
            check("done_reads", n_rd, len);
            finished = 1;
            start = 1'b0;
            out_ready = 1'b0;
         end else begin
            if (out_valid) begin
               if (n_out == stall_at && stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else begin
                  out_ready = ($urandom_range(99) >= stall_pct);
               end
               was_wait = !out_ready;
               if (out_ready) n_out++;
            end else begin
               out_ready = 1'($urandom_range(1));
               was_wait = 0;
            end
            if (noise) begin
               start  = 1'($urandom_range(1));
               length = ADDR_W'($urandom);
            end
         end
         @(negedge clock);
      end
      if (!finished) check("timeout", 0, 1);
      start = 1'b0;
      check("done_pulse_end", done, 0);
      check("busy_end", busy, 0);
      check("valid_end", out_valid, 0);
   endtask

   task automatic mid_reset();
      int n_out, cyc;
      bit hit;
      n_out = 0; cyc = 0; hit = 0;
      fill_random();
      @(negedge clock);
      start = 1'b1; length = 5; out_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      while (!hit && cyc < 60) begin
         cyc++;
         if (out_valid && n_out == 2) begin
            hit = 1;
         end else begin
            out_ready = out_valid;
            if (out_valid) n_out++;
            @(negedge clock);
         end
      end
      check("reach_entry2", hit, 1);
      out_ready = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clock);
      check("rst_no_done", done, 0);
      check("rst_idle", busy, 0);
      run_pass(5, 0, -1, 0, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; length = '0; out_ready = 1'b0;
      fill_random();
      repeat (2) @(negedge clock);
      check("reset_rd_en", rd_en, 0);
      check("reset_rd_addr", rd_addr, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_last", out_last, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b0;

      mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43;
      run_pass(3, 0, -1, 0, 0);

      run_pass(0, 0, -1, 0, 0);

      fill_random();
      run_pass(4, 0, 1, 5, 0);

      mid_reset();

      fill_random();
      run_pass(31, 30, -1, 0, 1);

      repeat (10) begin
         fill_random();
         run_pass(int'($urandom_range(31)), int'($urandom_range(60)), -1, 0, 1'($urandom_range(1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
